sobel_controller: RTL

Gradient stage directly downstream of the blur stage in the edge-detector pipeline. Each time the blur stage finishes a 16-pixel row segment, this block caches it in a 3-row window and computes the Sobel gradient magnitude for the 14 interior columns. It uses one time-multiplexed gradient datapath, producing one pixel per cycle. Results and a completion strobe go to the non-max-suppression stage.

---
 rtl/sobel_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sobel_controller.sv
// sobel_controller: Sobel gradient stage between the blur and non-max-suppression stages.
// Caches each incoming blurred row segment in a 3-row window and computes the
// saturated |Gx|+|Gy| magnitude for the SEG_WIDTH-2 interior columns, one per cycle.
// Optional feature macro: SOBEL_DIRECTION_EN adds quantized gradient direction.
// Ports:
//   clk, n_rst    clock, asynchronous active-low reset
//   blur_final    one-cycle strobe, blur_pixels holds a new segment
//   first_row     segment is image row 0 (replicated into the whole window)
//   blur_pixels   SEG_WIDTH x 8 blurred pixels
//   grad_out      (SEG_WIDTH-2) x 8 registered gradient magnitudes
//   grad_dir      (SEG_WIDTH-2) x 2 quantized direction (0 when feature absent)
//   grad_final    one-cycle strobe, whole output segment valid
//   busy          high while processing a segment
//   overrun       sticky, a segment arrived while mid-segment
module sobel_controller #(
    parameter int SEG_WIDTH = 16,
    parameter int SAT_MAX   = 255
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          blur_final,
    input  logic                          first_row,
    input  logic [SEG_WIDTH-1:0][7:0]     blur_pixels,
    output logic [SEG_WIDTH-3:0][7:0]     grad_out,
    output logic [SEG_WIDTH-3:0][1:0]     grad_dir,
    output logic                          grad_final,
    output logic                          busy,
    output logic                          overrun
);
    localparam int OW = SEG_WIDTH - 2;
    localparam int IW = $clog2(SEG_WIDTH);
    localparam logic [IW-1:0] LAST = IW'(SEG_WIDTH - 3);
    localparam logic [11:0] SAT = 12'(SAT_MAX);

    typedef enum logic {IDLE, PROCESS} state_t;

    state_t state_q, state_d;
    logic [IW-1:0] index_q, index_d, c1, c2;
    logic [SEG_WIDTH-1:0][7:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
    logic [OW-1:0][7:0] grad_out_q, grad_out_d;
    logic grad_final_q, grad_final_d, overrun_q, overrun_d;
    logic last, accept;
    logic [9:0] left, right, top, bot, ax, ay;
    logic signed [10:0] gx, gy;
    logic [11:0] mag;
    logic [7:0] sat;

    always_comb begin
        last   = (state_q == PROCESS) && (index_q == LAST);
        accept = blur_final && ((state_q == IDLE) || last);
        c1     = index_q + IW'(1);
        c2     = index_q + IW'(2);
        // Column/row weighted sums read the pre-shift cache, so the last
        // column of a segment is unaffected by a same-edge accept.
        left   = {2'b0, r2_q[index_q]} + {1'b0, r1_q[index_q], 1'b0} + {2'b0, r0_q[index_q]};
        right  = {2'b0, r2_q[c2]} + {1'b0, r1_q[c2], 1'b0} + {2'b0, r0_q[c2]};
        top    = {2'b0, r2_q[index_q]} + {1'b0, r2_q[c1], 1'b0} + {2'b0, r2_q[c2]};
        bot    = {2'b0, r0_q[index_q]} + {1'b0, r0_q[c1], 1'b0} + {2'b0, r0_q[c2]};
        gx     = $signed({1'b0, right}) - $signed({1'b0, left});
        gy     = $signed({1'b0, top}) - $signed({1'b0, bot});
        ax     = gx[10] ? 10'(-gx) : gx[9:0];
        ay     = gy[10] ? 10'(-gy) : gy[9:0];
        mag    = {2'b0, ax} + {2'b0, ay};
        sat    = (mag > SAT) ? 8'(SAT_MAX) : mag[7:0];
        state_d      = state_q;
        index_d      = index_q;
        r0_d         = r0_q;
        r1_d         = r1_q;
        r2_d         = r2_q;
        grad_out_d   = grad_out_q;
        grad_final_d = last;
        overrun_d    = overrun_q | (blur_final && (state_q == PROCESS) && !last);
        if (state_q == PROCESS) begin
            grad_out_d[index_q] = sat;
            index_d = index_q + IW'(1);
            state_d = last ? IDLE : PROCESS;
        end
        if (accept) begin
            // A top-border row is replicated so the window has zero Gy.
            r2_d    = first_row ? blur_pixels : r1_q;
            r1_d    = first_row ? blur_pixels : r0_q;
            r0_d    = blur_pixels;
            index_d = '0;
            state_d = PROCESS;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            index_q      <= '0;
            r0_q         <= '0;
            r1_q         <= '0;
            r2_q         <= '0;
            grad_out_q   <= '0;
            grad_final_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            r0_q         <= r0_d;
            r1_q         <= r1_d;
            r2_q         <= r2_d;
            grad_out_q   <= grad_out_d;
            grad_final_q <= grad_final_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef SOBEL_DIRECTION_EN
    logic [OW-1:0][1:0] grad_dir_q, grad_dir_d;
    logic [1:0] dir;

    always_comb begin
        // Zero gradient falls into the first test and yields 0.
        dir = ({1'b0, ax} >= {ay, 1'b0}) ? 2'd0 :
              ({1'b0, ay} >= {ax, 1'b0}) ? 2'd2 :
              (gx[10] == gy[10])         ? 2'd1 : 2'd3;
        grad_dir_d = grad_dir_q;
        if (state_q == PROCESS) grad_dir_d[index_q] = dir;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) grad_dir_q <= '0;
        else        grad_dir_q <= grad_dir_d;
    end

    assign grad_dir = grad_dir_q;
`else
    assign grad_dir = '0;
`endif

    assign grad_out   = grad_out_q;
    assign grad_final = grad_final_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q == PROCESS);
endmodule
